// File: rtl/mips32_pkg.sv
// Shared encodings for the mips32 run/load sequencer: command codes, error codes and FSM states.
package mips32_pkg;

  localparam logic [1:0] CMD_LOAD  = 2'b00;
  localparam logic [1:0] CMD_RUN   = 2'b01;
  localparam logic [1:0] CMD_STEP  = 2'b10;
  localparam logic [1:0] CMD_ABORT = 2'b11;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_OVF   = 2'b01;
  localparam logic [1:0] ERR_WDOG  = 2'b10;
  localparam logic [1:0] ERR_ILL   = 2'b11;

  // Opcode the core decodes as hlt.
  localparam logic [5:0] HALT_OP = 6'b111111;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StClr,
    StRun,
    StStep,
    StHalted
  } state_e;

endpackage

// File: rtl/mips32_imem_loader.sv
// Instruction-memory loader: write pointer, word count, end-of-memory flag and registered
// write port.
module mips32_imem_loader #(
  parameter int unsigned IMEM_DEPTH = 1024,
  localparam int unsigned AW = $clog2(IMEM_DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_start,
  input  logic          i_wr_en,
  input  logic [31:0]   i_wr_data,
  output logic          o_at_end,
  output logic          o_imem_we,
  output logic [AW-1:0] o_imem_addr,
  output logic [31:0]   o_imem_wdata,
  output logic [AW:0]   o_load_cnt
);

  logic [AW-1:0] r_ptr;
  logic [AW:0]   r_cnt;
  logic          r_imem_we;
  logic [AW-1:0] r_imem_addr;
  logic [31:0]   r_imem_wdata;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr        <= '0;
      r_cnt        <= '0;
      r_imem_we    <= 1'b0;
      r_imem_addr  <= '0;
      r_imem_wdata <= '0;
    end else begin
      r_imem_we <= i_wr_en;
      if (i_start) begin
        r_ptr <= '0;
        r_cnt <= '0;
      end else if (i_wr_en) begin
        r_imem_addr  <= r_ptr;
        r_imem_wdata <= i_wr_data;
        r_ptr        <= r_ptr + AW'(1);
        r_cnt        <= r_cnt + (AW + 1)'(1);
      end
    end
  end

  // The word accepted at this pointer is the last one that fits.
  assign o_at_end     = (r_ptr == AW'(IMEM_DEPTH - 1));
  assign o_imem_we    = r_imem_we;
  assign o_imem_addr  = r_imem_addr;
  assign o_imem_wdata = r_imem_wdata;
  assign o_load_cnt   = r_cnt;

endmodule

// File: rtl/mips32_run_ctrl.sv
// Run/load sequencer for the mips32 core: loads instruction memory, then clears and enables
// the core until halt, watchdog expiry or abort, with single-step support.
module mips32_run_ctrl
  import mips32_pkg::*;
#(
  parameter int unsigned IMEM_DEPTH = 1024,
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned MAX_CYCLES = 2 ** 20,
  localparam int unsigned AW = $clog2(IMEM_DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_cmd_valid,
  input  logic [1:0]       i_cmd_op,
  output logic             o_cmd_ready,
  input  logic             i_ld_valid,
  input  logic             i_ld_last,
  input  logic [31:0]      i_ld_data,
  output logic             o_ld_ready,
  output logic             o_imem_we,
  output logic [AW-1:0]    o_imem_addr,
  output logic [31:0]      o_imem_wdata,
  output logic             o_core_clr,
  output logic             o_core_en,
  input  logic             i_core_hlt,
  output logic             o_busy,
  output logic             o_done,
  output logic [1:0]       o_err,
  output logic [AW:0]      o_load_cnt,
  output logic [CNT_W-1:0] o_cycle_cnt
);

  state_e             r_state, w_state_nxt;
  logic [1:0]         r_err, w_err_nxt;
  logic [CNT_W-1:0]   r_cycle_cnt;
  logic               w_cnt_clr, w_cnt_inc, w_ld_start, w_at_end, w_wdog;
  logic               w_cmd_fire, w_ld_fire;

  assign w_cmd_fire = i_cmd_valid & o_cmd_ready;
  assign w_ld_fire  = i_ld_valid & o_ld_ready;
  assign w_wdog     = (r_cycle_cnt == CNT_W'(MAX_CYCLES - 1));

  mips32_imem_loader #(
    .IMEM_DEPTH (IMEM_DEPTH)
  ) u_loader (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_start      (w_ld_start),
    .i_wr_en      (w_ld_fire),
    .i_wr_data    (i_ld_data),
    .o_at_end     (w_at_end),
    .o_imem_we    (o_imem_we),
    .o_imem_addr  (o_imem_addr),
    .o_imem_wdata (o_imem_wdata),
    .o_load_cnt   (o_load_cnt)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= StIdle;
      r_err       <= ERR_NONE;
      r_cycle_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_err   <= w_err_nxt;
      if (w_cnt_clr) begin
        r_cycle_cnt <= '0;
      end else if (w_cnt_inc && (r_cycle_cnt != '1)) begin
        r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_err_nxt   = r_err;
    w_cnt_clr   = 1'b0;
    w_cnt_inc   = 1'b0;
    w_ld_start  = 1'b0;
    unique case (r_state)
      StIdle, StHalted: begin
        if (w_cmd_fire) begin
          case (i_cmd_op)
            CMD_LOAD: begin
              w_state_nxt = StLoad;
              w_ld_start  = 1'b1;
              w_err_nxt   = ERR_NONE;
            end
            CMD_RUN: begin
              w_state_nxt = StClr;
              w_err_nxt   = ERR_NONE;
            end
            CMD_STEP: begin
              if (r_state == StIdle) w_state_nxt = StStep;
              else                   w_err_nxt   = ERR_ILL;
            end
            default: w_state_nxt = StIdle;
          endcase
        end
      end
      StLoad: begin
        if (w_cmd_fire) begin
          if (i_cmd_op == CMD_ABORT)     w_state_nxt = StIdle;
          else if (i_cmd_op != CMD_LOAD) w_err_nxt   = ERR_ILL;
        end
        // A word accepted alongside ABORT is still written by the loader.
        if (w_ld_fire) begin
          if (i_ld_last) begin
            w_state_nxt = StIdle;
          end else if (w_at_end) begin
            w_state_nxt = StIdle;
            w_err_nxt   = ERR_OVF;
          end
        end
      end
      StClr: begin
        w_cnt_clr   = 1'b1;
        w_state_nxt = StRun;
      end
      StRun: begin
        w_cnt_inc = 1'b1;
        if (w_cmd_fire && (i_cmd_op == CMD_ABORT)) begin
          w_state_nxt = StIdle;
        end else begin
          if (w_cmd_fire) w_err_nxt = ERR_ILL;
          // A genuine halt beats a coincident watchdog expiry.
          if (i_core_hlt) begin
            w_state_nxt = StHalted;
          end else if (w_wdog) begin
            w_state_nxt = StHalted;
            w_err_nxt   = ERR_WDOG;
          end
        end
      end
      StStep: begin
        w_cnt_inc   = 1'b1;
        w_state_nxt = i_core_hlt ? StHalted : StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_comb begin
    o_cmd_ready = 1'b0;
    o_ld_ready  = 1'b0;
    o_core_clr  = 1'b0;
    o_core_en   = 1'b0;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    unique case (r_state)
      StIdle:   o_cmd_ready = 1'b1;
      StLoad: begin
        o_cmd_ready = 1'b1;
        o_ld_ready  = 1'b1;
        o_busy      = 1'b1;
      end
      StClr: begin
        o_core_clr = 1'b1;
        o_busy     = 1'b1;
      end
      StRun: begin
        o_cmd_ready = 1'b1;
        o_core_en   = 1'b1;
        o_busy      = 1'b1;
      end
      StStep: begin
        o_core_en = 1'b1;
        o_busy    = 1'b1;
      end
      StHalted: begin
        o_cmd_ready = 1'b1;
        o_done      = 1'b1;
      end
      default: ;
    endcase
  end

  assign o_err       = r_err;
  assign o_cycle_cnt = r_cycle_cnt;

endmodule
